mem_responder: RTL and testbench

Single-port, word-organised memory model that is the responder on the decoupled request/response protocol used by the fetch stage and other initiators. It accepts one request per cycle on `mem_req`, performs writes immediately, returns read data in order on `mem_resp` after a fixed pipeline latency, and buffers responses against downstream backpressure. It sits between an initiator (or arbiter output) and the top-level memory, and is used both in synthesis and as the simulation memory.

---
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Decoupled request and response channels for the memory responder.
// Requests carry a byte address, write enable, byte enables and write data.
interface mem_req_if;
  logic        valid;
  logic        ready;
  logic [31:0] a;
  logic        we;
  logic [3:0]  be;
  logic [31:0] d;

  modport master (
    output valid, a, we, be, d,
    input  ready
  );

  modport slave (
    input  valid, a, we, be, d,
    output ready
  );
endinterface

interface mem_resp_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport master (
    output valid, data,
    input  ready
  );

  modport slave (
    input  valid, data,
    output ready
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory responder: posted byte-masked writes, in-order
// reads through a fixed-latency pipeline and a credit-limited response FIFO.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  mem_req_if.slave                        mem_req,
  mem_resp_if.master                      mem_resp,
  output logic [$clog2(RESP_DEPTH+1)-1:0] outstanding
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          req_fire;
  logic          rd_fire;
  logic          wr_fire;
  logic [31:0]   rd_word;

  logic          push;
  logic [31:0]   push_data;
  logic          pop;

  logic [31:0]   fifo [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] credit;

  logic          unused;

  assign unused = ^{mem_req.a[31:AW+2], mem_req.a[1:0]};

  // Credit covers pipeline plus FIFO, so the FIFO can never overflow.
  assign mem_req.ready = rst && (credit < FULL);
  assign outstanding   = credit;

  assign idx      = mem_req.a[AW+1:2];
  assign req_fire = mem_req.valid && mem_req.ready;
  assign rd_fire  = req_fire && !mem_req.we;
  assign wr_fire  = req_fire && mem_req.we;
  assign rd_word  = mem[idx];

  assign mem_resp.valid = (count != '0);
  assign mem_resp.data  = fifo[rd_ptr];
  assign pop            = mem_resp.valid && mem_resp.ready;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_req.be[i]) begin
          mem[idx][8*i +: 8] <= mem_req.d[8*i +: 8];
        end
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push      = rd_fire;
      assign push_data = rd_word;
    end else begin : g_pipe
      logic [LATENCY-2:0] v;
      logic [31:0]        d [LATENCY-1];

      always_ff @(posedge clk) begin
        if (!rst) begin
          v <= '0;
        end else begin
          v[0] <= rd_fire;
          for (int i = 1; i < LATENCY - 1; i++) begin
            v[i] <= v[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        d[0] <= rd_word;
        for (int i = 1; i < LATENCY - 1; i++) begin
          d[i] <= d[i-1];
        end
      end

      assign push      = v[LATENCY-2];
      assign push_data = d[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      credit <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      unique case ({rd_fire, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst) push |-> (count < FULL)
  );

  a_credit_covers: assert property (
    @(posedge clk) disable iff (!rst) count <= credit
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder, checked against a
// queue-based behavioural model of memory contents and response timing.
module tb_mem_responder;

  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam int RD  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] outstanding;

  always #5 clk = ~clk;

  mem_req_if  req ();
  mem_resp_if rsp ();

  mem_responder #(
    .DEPTH_WORDS (DW),
    .LATENCY     (LAT),
    .RESP_DEPTH  (RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (req),
    .mem_resp    (rsp),
    .outstanding (outstanding)
  );

  typedef struct {
    logic [31:0] data;
    int          t;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] mm [int];
  ent_t        q [$];
  logic [31:0] exp8 [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DW);
  endfunction

  task automatic idle();
    req.valid = 1'b0;
    req.we    = 1'b0;
    req.a     = '0;
    req.be    = '0;
    req.d     = '0;
  endtask

  // Compare outputs mid-cycle, then advance model and clock by one edge.
  task automatic tick();
    logic        exp_rdy;
    logic        exp_v;
    logic        acc;
    logic        pop;
    logic [31:0] cur;
    int          k;
    @(negedge clk);
    exp_rdy = rst && (q.size() < RD);
    exp_v   = (q.size() > 0) && (cyc >= q[0].t + LAT);
    chk("req_ready", req.ready, exp_rdy);
    chk("resp_valid", rsp.valid, exp_v);
    chk("outstanding", outstanding, q.size());
    if (exp_v && rsp.valid) chk("resp_data", rsp.data, q[0].data);
    acc = req.valid && exp_rdy;
    pop = exp_v && rsp.ready;
    @(posedge clk);
    if (!rst) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        k   = widx(req.a);
        cur = mm.exists(k) ? mm[k] : 32'h0;
        if (req.we) begin
          for (int i = 0; i < 4; i++)
            if (req.be[i]) cur[8*i +: 8] = req.d[8*i +: 8];
          mm[k] = cur;
        end else begin
          q.push_back('{data: cur, t: cyc});
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    req.valid = 1'b1;
    req.we    = 1'b1;
    req.a     = a;
    req.be    = be;
    req.d     = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    req.valid = 1'b1;
    req.we    = 1'b0;
    req.a     = a;
    req.be    = 4'($urandom);
    req.d     = $urandom;
    tick();
    idle();
  endtask

  initial begin
    int n;
    logic [31:0] r;
    idle();
    rsp.ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    wr(32'h100, 4'hf, 32'hDEADBEEF);
    rd(32'h100);
    chk("t1_early", rsp.valid, 1'b0);
    tick();
    chk("t1_valid", rsp.valid, 1'b1);
    chk("t1_data", rsp.data, 32'hDEADBEEF);
    tick();

    wr(32'h200, 4'hf, 32'h11223344);
    wr(32'h200, 4'b0101, 32'hAABBCCDD);
    rd(32'h200);
    rd(32'h203);
    chk("t2_data0", rsp.data, 32'h11BB33DD);
    tick();
    chk("t2_data1", rsp.data, 32'h11BB33DD);
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      exp8[i] = $urandom;
      wr(32'h400 + 4 * i, 4'hf, exp8[i]);
    end
    n = 0;
    for (int k = 0; k < 8 + LAT; k++) begin
      if (k < 8) begin
        req.valid = 1'b1;
        req.we    = 1'b0;
        req.a     = 32'h400 + 4 * k;
      end else begin
        idle();
      end
      tick();
      chk("b2b_valid", rsp.valid, (k + 1 >= LAT) && (k + 1 - LAT < 8));
      chk("b2b_ready", req.ready, 1'b1);
      if (rsp.valid && n < 8) begin
        chk("b2b_data", rsp.data, exp8[n]);
        n++;
      end
    end
    chk("b2b_count", n, 8);
    idle();
    repeat (2) tick();

    rsp.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req.valid = 1'b1;
      req.we    = 1'b0;
      req.a     = 32'h400 + 4 * i;
      tick();
    end
    idle();
    chk("bp_outst", outstanding, 4);
    chk("bp_ready", req.ready, 1'b0);
    chk("bp_valid", rsp.valid, 1'b1);
    chk("bp_head", rsp.data, exp8[0]);
    repeat (2) tick();
    chk("bp_stable", rsp.data, exp8[0]);
    rsp.ready = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp.valid && n < 8) begin
        chk("bp_data", rsp.data, exp8[n]);
        n++;
      end
      tick();
      if (k == 0) chk("bp_credit", req.ready, 1'b1);
    end
    chk("bp_count", n, 4);

    wr(32'h0, 4'hf, 32'h5);
    rd(4 * DW);
    tick();
    chk("alias_data", rsp.data, 32'h5);
    repeat (2) tick();

    wr(32'h300, 4'hf, 32'hCAFEF00D);
    rsp.ready = 1'b0;
    rd(32'h400);
    rd(32'h404);
    rd(32'h408);
    rst = 1'b0;
    tick();
    chk("rst_valid", rsp.valid, 1'b0);
    chk("rst_outst", outstanding, 0);
    rst       = 1'b1;
    rsp.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_stale", rsp.valid, 1'b0);
    end
    rd(32'h300);
    tick();
    chk("rst_keep", rsp.data, 32'hCAFEF00D);
    tick();

    for (int i = 0; i < 16; i++)
      wr(32'h100 + 4 * i, 4'hf, $urandom);
    for (int i = 0; i < 600; i++) begin
      r         = $urandom;
      rst       = ($urandom_range(0, 199) != 0);
      rsp.ready = ($urandom_range(0, 9) < 7);
      req.valid = ($urandom_range(0, 9) < 7);
      req.we    = ($urandom_range(0, 9) < 3);
      req.a     = (r & 32'hFFFF_F000) | (32'h100 + 4 * $urandom_range(0, 15))
                | ($urandom & 32'h3);
      req.be    = 4'($urandom);
      req.d     = $urandom;
      tick();
    end
    rst = 1'b1;
    idle();
    rsp.ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
